sequence_detector_param: RTL and testbench
==========================================

// Module: sequence_detector_param
// PURPOSE
//  Parametrised successor to the 8-bit lock: secret of SEQ_LEN bits entered from board switches,
//  guessed bit-serially from the PS over GPIO. Tracks longest secret-prefix matching guess-suffix,
//  timed red flash on a broken run, green on unlock. Sits between board I/O and PS GPIO.
// PARAMETERS
//  SEQ_LEN       8           secret length in bits, legal 2..16
//  FLASH_CYCLES  125000000   red flash duration in clk cycles (1 s at 125 MHz), >=1
//  MAX_FAILS     3           mismatches before lockout (SEQ_DET_LOCKOUT_EN only), >=1
//  CW (local)    $clog2(SEQ_LEN+1)  count width
// PORTS
//  clk          in   1     system clock
//  reset_n      in   1     asynchronous, active-low reset
//  set_btn      in   1     secret-entry enable (level)
//  sw0          in   1     secret bit value
//  sw1          in   1     secret bit strobe (rising edge)
//  ps_gpio_in   in   2     [1]=guess strobe (rising edge), [0]=guess bit
//  leds         out  CW    secret_count in SET, else match_len
//  rgb_led1     out  3     {R,G,B} status
//  rgb_led2     out  3     {R,G,B} status, mirrors rgb_led1
//  ps_gpio_out  out  CW    match_len to PS
//  unlocked     out  1     high in UNLOCKED
// BEHAVIOUR
//  - Reset (async assert, sync release): secret, guess, secret_count, match_len, fail_cnt, flash
//    timer = 0; state SET; leds=0, rgb=3'b001, ps_gpio_out=0, unlocked=0. Any time, mid-operation.
//  - sw1, ps_gpio_in[1:0] pass 2-FF synchronisers; rising edge of synced strobe = 1-cycle pulse.
//    Data bit taken from synced ps_gpio_in[0] in the pulse cycle; stable >=3 clk around strobe.
//  - States: SET -> ARMED <-> FLASH -> UNLOCKED; LOCKED with macro only.
//  - SET: on sw1 pulse with set_btn=1: secret <= {secret[SEQ_LEN-2:0],sw0}, secret_count++.
//    First bit entered = secret MSB. Pulses without set_btn ignored. secret_count==SEQ_LEN
//    -> ARMED next cycle. Guess pulses ignored in SET.
//  - ARMED/FLASH: on guess pulse: guess <= {guess[SEQ_LEN-2:0],bit}; match_len <= largest
//    k in 0..SEQ_LEN with new guess[k-1:0] == secret[SEQ_LEN-1 -: k]. Registered: visible on
//    ps_gpio_out/leds the cycle after the pulse.
//  - Mismatch: new match_len != old match_len+1 -> FLASH, timer restarts from 0 (retrigger OK);
//    FLASH -> ARMED after FLASH_CYCLES cycles with no new mismatch. Guesses accepted in FLASH.
//  - new match_len == SEQ_LEN -> UNLOCKED (overrides mismatch/flash); holds until reset;
//    guess and sw1 pulses ignored; leds/ps_gpio_out hold SEQ_LEN.
//  - sw1 ignored outside SET; guess ignored outside ARMED/FLASH -> never two writers in one cycle.
//  - rgb: SET 001, ARMED 000, FLASH 100, UNLOCKED 010, LOCKED 101. No counter wraps: secret_count
//    saturates at SEQ_LEN, fail_cnt at MAX_FAILS.
// CONFIGURATION
//  SEQ_DET_LOCKOUT_EN defined: fail_cnt++ per mismatch; mismatch reaching MAX_FAILS ->
//    LOCKED (priority over FLASH): guesses ignored, ps_gpio_out=0, leds=0, rgb=101; exit by
//    reset only. A correct SEQ_LEN-th bit still unlocks even at MAX_FAILS-1 fails.
//  Undefined: no fail_cnt, LOCKED unreachable, unlimited guesses.
// TESTING (SEQ_LEN=8, FLASH_CYCLES=16, MAX_FAILS=3)
//  1 set_btn=1, 8 sw1 strobes bits 1,0,1,1,0,0,1,0 -> leds 1..8, rgb 001 then 000; 9th strobe ignored.
//  2 guess 1,0,1,1,0,0,1,0 -> ps_gpio_out 1..8, rgb 010, unlocked=1; further guesses no effect.
//  3 guess 1,0,1,0 -> ps_gpio_out 1,2,3,2; rgb 100 exactly 16 cycles after 4th, then 000.
//  4 guess 1,1 then 0,1,1,0,0,1,0 -> 1,1(flash),2..8, unlock; strobe during flash extends flash.
//  5 macro on: 3 mismatches -> rgb 101, ps_gpio_out 0, correct sequence ignored; macro off: unlocks.
//  6 reset_n low mid-guess (match_len=5) -> outputs cleared same cycle without clk, rgb 001.

Source files
------------

// File: rtl/sequence_detector_param.sv
// Bit-serial combination lock: secret entered from switches, guessed over PS GPIO, longest
// secret-prefix / guess-suffix tracking. Define SEQ_DET_LOCKOUT_EN to add the MAX_FAILS lockout.
module sequence_detector_param #(
  parameter int SEQ_LEN      = 8,
  parameter int FLASH_CYCLES = 125000000,
  parameter int MAX_FAILS    = 3,
  localparam int CW          = $clog2(SEQ_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          set_btn,
  input  logic          sw0,
  input  logic          sw1,
  input  logic [1:0]    ps_gpio_in,
  output logic [CW-1:0] leds,
  output logic [2:0]    rgb_led1,
  output logic [2:0]    rgb_led2,
  output logic [CW-1:0] ps_gpio_out,
  output logic          unlocked
);

  localparam int TW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [CW-1:0] SEQ_FULL   = CW'(SEQ_LEN);
  localparam logic [TW-1:0] FLASH_LAST = TW'(FLASH_CYCLES - 1);
`ifdef SEQ_DET_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);
`endif

  if (SEQ_LEN < 2 || SEQ_LEN > 16 || FLASH_CYCLES < 1 || MAX_FAILS < 1) begin : g_param_check
    $error("sequence_detector_param: illegal parameter value");
  end

  typedef enum logic [2:0] {
    ST_SET      = 3'd0,
    ST_ARMED    = 3'd1,
    ST_FLASH    = 3'd2,
    ST_UNLOCKED = 3'd3,
    ST_LOCKED   = 3'd4
  } state_e;

  // Longest k such that the newest k guess bits equal the first k secret bits.
  function automatic logic [CW-1:0] calc_match(input logic [SEQ_LEN-1:0] sec,
                                               input logic [SEQ_LEN-1:0] gss);
    logic [CW-1:0]      best;
    logic [SEQ_LEN-1:0] mask;
    best = '0;
    for (int k = 1; k <= SEQ_LEN; k++) begin
      mask = {SEQ_LEN{1'b1}} >> (SEQ_LEN - k);
      best = ((gss & mask) == ((sec >> (SEQ_LEN - k)) & mask)) ? CW'(k) : best;
    end
    return best;
  endfunction

  logic               sw1_meta_r, sw1_sync_r, sw1_prev_r;
  logic [1:0]         gpio_meta_r, gpio_sync_r;
  logic               gstb_prev_r;
  logic               sw1_pulse_s, guess_pulse_s;

  state_e             state_r, state_s;
  logic [SEQ_LEN-1:0] secret_r, secret_s, guess_r, guess_s, new_guess_s;
  logic [CW-1:0]      count_r, count_s, match_r, match_s, new_match_s, match_inc_s;
  logic [TW-1:0]      timer_r, timer_s;
`ifdef SEQ_DET_LOCKOUT_EN
  logic [FW-1:0]      fail_r, fail_s;
`endif

  logic [CW-1:0]      leds_r, leds_s, gpio_out_r, gpio_out_s;
  logic [2:0]         rgb_r, rgb_s;
  logic               unlocked_r, unlocked_s;

  // Two-flop synchronisers plus previous-value flops for strobe edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw1_meta_r  <= 1'b0;
      sw1_sync_r  <= 1'b0;
      sw1_prev_r  <= 1'b0;
      gpio_meta_r <= 2'b00;
      gpio_sync_r <= 2'b00;
      gstb_prev_r <= 1'b0;
    end else begin
      sw1_meta_r  <= sw1;
      sw1_sync_r  <= sw1_meta_r;
      sw1_prev_r  <= sw1_sync_r;
      gpio_meta_r <= ps_gpio_in;
      gpio_sync_r <= gpio_meta_r;
      gstb_prev_r <= gpio_sync_r[1];
    end
  end

  assign sw1_pulse_s   = sw1_sync_r & ~sw1_prev_r;
  assign guess_pulse_s = gpio_sync_r[1] & ~gstb_prev_r;
  assign new_guess_s   = {guess_r[SEQ_LEN-2:0], gpio_sync_r[0]};
  assign new_match_s   = calc_match(secret_r, new_guess_s);
  assign match_inc_s   = match_r + CW'(1);

  // Next-state logic: secret entry, guess tracking, flash timing and terminal states.
  always_comb begin
    state_s  = state_r;
    secret_s = secret_r;
    count_s  = count_r;
    guess_s  = guess_r;
    match_s  = match_r;
    timer_s  = timer_r;
`ifdef SEQ_DET_LOCKOUT_EN
    fail_s   = fail_r;
`endif
    case (state_r)
      ST_SET: begin
        if (count_r == SEQ_FULL) begin
          state_s = ST_ARMED;
        end else if (sw1_pulse_s && set_btn) begin
          secret_s = {secret_r[SEQ_LEN-2:0], sw0};
          count_s  = count_r + CW'(1);
        end else begin
          state_s = ST_SET;
        end
      end
      ST_ARMED, ST_FLASH: begin
        if (state_r == ST_FLASH && timer_r == FLASH_LAST) begin
          state_s = ST_ARMED;
          timer_s = '0;
        end else if (state_r == ST_FLASH) begin
          timer_s = timer_r + TW'(1);
        end else begin
          timer_s = '0;
        end
        if (guess_pulse_s) begin
          guess_s = new_guess_s;
          match_s = new_match_s;
          // A full match wins over any mismatch or lockout decision.
          if (new_match_s == SEQ_FULL) begin
            state_s = ST_UNLOCKED;
          end else if (new_match_s != match_inc_s) begin
`ifdef SEQ_DET_LOCKOUT_EN
            if (fail_r == FAIL_LAST) begin
              fail_s  = FAIL_MAX;
              state_s = ST_LOCKED;
            end else begin
              fail_s  = fail_r + FW'(1);
              state_s = ST_FLASH;
              timer_s = '0;
            end
`else
            state_s = ST_FLASH;
            timer_s = '0;
`endif
          end else begin
            match_s = new_match_s;
          end
        end else begin
          guess_s = guess_r;
        end
      end
      ST_UNLOCKED: state_s = ST_UNLOCKED;
      ST_LOCKED:   state_s = ST_LOCKED;
      default:     state_s = ST_SET;
    endcase
  end

  // Output values derived from the next state so they register alongside it.
  always_comb begin
    leds_s     = '0;
    gpio_out_s = '0;
    rgb_s      = 3'b001;
    unlocked_s = 1'b0;
    case (state_s)
      ST_SET: begin
        leds_s     = count_s;
        gpio_out_s = match_s;
        rgb_s      = 3'b001;
      end
      ST_ARMED: begin
        leds_s     = match_s;
        gpio_out_s = match_s;
        rgb_s      = 3'b000;
      end
      ST_FLASH: begin
        leds_s     = match_s;
        gpio_out_s = match_s;
        rgb_s      = 3'b100;
      end
      ST_UNLOCKED: begin
        leds_s     = match_s;
        gpio_out_s = match_s;
        rgb_s      = 3'b010;
        unlocked_s = 1'b1;
      end
      ST_LOCKED: begin
        leds_s     = '0;
        gpio_out_s = '0;
        rgb_s      = 3'b101;
      end
      default: begin
        leds_s     = '0;
        gpio_out_s = '0;
        rgb_s      = 3'b001;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_SET;
      secret_r   <= '0;
      count_r    <= '0;
      guess_r    <= '0;
      match_r    <= '0;
      timer_r    <= '0;
`ifdef SEQ_DET_LOCKOUT_EN
      fail_r     <= '0;
`endif
      leds_r     <= '0;
      gpio_out_r <= '0;
      rgb_r      <= 3'b001;
      unlocked_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      secret_r   <= secret_s;
      count_r    <= count_s;
      guess_r    <= guess_s;
      match_r    <= match_s;
      timer_r    <= timer_s;
`ifdef SEQ_DET_LOCKOUT_EN
      fail_r     <= fail_s;
`endif
      leds_r     <= leds_s;
      gpio_out_r <= gpio_out_s;
      rgb_r      <= rgb_s;
      unlocked_r <= unlocked_s;
    end
  end

  assign leds        = leds_r;
  assign ps_gpio_out = gpio_out_r;
  assign rgb_led1    = rgb_r;
  assign rgb_led2    = rgb_r;
  assign unlocked    = unlocked_r;

endmodule

// File: tb/tb_sequence_detector_param.sv
// Bench for sequence_detector_param: directed vector table, hand-written corner sequences and
// randomized guesses against a queue-based reference model. Honours SEQ_DET_LOCKOUT_EN.
module tb_sequence_detector_param;
  localparam int SEQ_LEN      = 8;
  localparam int FLASH_CYCLES = 16;
  localparam int MAX_FAILS    = 3;
  localparam int CW           = 4;

  logic          clk;
  logic          reset_n;
  logic          set_btn;
  logic          sw0;
  logic          sw1;
  logic [1:0]    ps_gpio_in;
  logic [CW-1:0] leds;
  logic [2:0]    rgb_led1;
  logic [2:0]    rgb_led2;
  logic [CW-1:0] ps_gpio_out;
  logic          unlocked;

  sequence_detector_param #(
    .SEQ_LEN(SEQ_LEN), .FLASH_CYCLES(FLASH_CYCLES), .MAX_FAILS(MAX_FAILS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .set_btn(set_btn), .sw0(sw0), .sw1(sw1),
    .ps_gpio_in(ps_gpio_in), .leds(leds), .rgb_led1(rgb_led1), .rgb_led2(rgb_led2),
    .ps_gpio_out(ps_gpio_out), .unlocked(unlocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model: entered bits in order, guess history, and event cycle stamps.
  bit m_secret[$];
  bit m_hist[$];
  int m_match, m_fails, m_armed_cyc, m_flash_end;
  bit m_unl, m_locked;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_secret.delete();
    m_hist.delete();
    for (int i = 0; i < SEQ_LEN; i++) m_hist.push_back(1'b0);
    m_match = 0; m_fails = 0; m_unl = 0; m_locked = 0;
    m_armed_cyc = 32'h7fffffff; m_flash_end = 0;
  endtask

  function automatic int model_match();
    int n;
    bit ok;
    n = m_hist.size();
    for (int k = SEQ_LEN; k >= 1; k--) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) if (m_hist[n-k+i] != m_secret[i]) ok = 1'b0;
      if (ok) return k;
    end
    return 0;
  endfunction

  // p = cycle at whose clock edge the strobe takes effect.
  task automatic model_secret(input bit b, input int p);
    if (p - 1 < m_armed_cyc && set_btn && m_secret.size() < SEQ_LEN) begin
      m_secret.push_back(b);
      if (m_secret.size() == SEQ_LEN) m_armed_cyc = p + 1;
    end
  endtask

  task automatic model_guess(input bit b, input int p);
    int m;
    if (m_unl || m_locked || p - 1 < m_armed_cyc) return;
    m_hist.push_back(b);
    void'(m_hist.pop_front());
    m = model_match();
    if (m == SEQ_LEN) m_unl = 1'b1;
    else if (m != m_match + 1) begin
`ifdef SEQ_DET_LOCKOUT_EN
      m_fails++;
      if (m_fails >= MAX_FAILS) m_locked = 1'b1;
      else m_flash_end = p + FLASH_CYCLES;
`else
      m_flash_end = p + FLASH_CYCLES;
`endif
    end
    m_match = m;
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] el, eg;
    logic [2:0] er;
    logic       eu;
    eu = 1'b0;
    eg = 4'(m_match);
    if (m_locked) begin
      el = 4'd0; eg = 4'd0; er = 3'b101;
    end else if (m_unl) begin
      el = 4'(m_match); er = 3'b010; eu = 1'b1;
    end else if (cyc < m_armed_cyc) begin
      el = 4'(m_secret.size()); er = 3'b001;
    end else begin
      el = 4'(m_match); er = (cyc < m_flash_end) ? 3'b100 : 3'b000;
    end
    check($sformatf("%s leds", tag), leds, el);
    check($sformatf("%s gpio_out", tag), ps_gpio_out, eg);
    check($sformatf("%s rgb1", tag), rgb_led1, er);
    check($sformatf("%s rgb2", tag), rgb_led2, er);
    check($sformatf("%s unlocked", tag), unlocked, eu);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; set_btn = 1'b0; sw0 = 1'b0; sw1 = 1'b0; ps_gpio_in = 2'b00;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Raise a strobe with data set up 3 cycles earlier; return in the first cycle the result shows.
  task automatic strobe_start(input bit is_guess, input bit b, output int p);
    if (is_guess) ps_gpio_in = {1'b0, b}; else sw0 = b;
    repeat (3) @(negedge clk);
    if (is_guess) ps_gpio_in = {1'b1, b}; else sw1 = 1'b1;
    p = cyc + 3;
    if (is_guess) model_guess(b, p); else model_secret(b, p);
    repeat (3) @(negedge clk);
  endtask

  task automatic strobe_end(input bit is_guess, input bit b);
    @(negedge clk);
    if (is_guess) ps_gpio_in = {1'b0, b}; else sw1 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_strobe(input bit is_guess, input bit b, input string tag, output int p);
    strobe_start(is_guess, b, p);
    check_outputs(tag);
    strobe_end(is_guess, b);
  endtask

  task automatic enter_secret(input logic [7:0] s);
    int p;
    set_btn = 1'b1;
    for (int i = 7; i >= 0; i--) do_strobe(1'b0, s[i], $sformatf("secret%0d", 7 - i), p);
    set_btn = 1'b0;
  endtask

  task automatic guesses(input logic [15:0] g, input int n, input string tag, output int p);
    for (int i = n - 1; i >= 0; i--) do_strobe(1'b1, g[i], $sformatf("%s_g%0d", tag, n - i), p);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  typedef struct packed {
    logic       is_guess;
    logic       sb;
    logic       b;
    logic [3:0] leds;
    logic [2:0] rgb;
    logic [3:0] gpio;
    logic       unl;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int p, m1, m2;
    logic [7:0] rs;
    bit rb;

    // secret strobes (one without set_btn), a guess in SET, 9th strobe, guesses, post-unlock
    vecs.push_back({1'b0, 1'b0, 1'b1, 4'd0, 3'b001, 4'd0, 1'b0});
    vecs.push_back({1'b1, 1'b0, 1'b1, 4'd0, 3'b001, 4'd0, 1'b0});
    vecs.push_back({1'b0, 1'b1, 1'b1, 4'd1, 3'b001, 4'd0, 1'b0});
    vecs.push_back({1'b0, 1'b1, 1'b0, 4'd2, 3'b001, 4'd0, 1'b0});
    vecs.push_back({1'b0, 1'b1, 1'b1, 4'd3, 3'b001, 4'd0, 1'b0});
    vecs.push_back({1'b0, 1'b1, 1'b1, 4'd4, 3'b001, 4'd0, 1'b0});
    vecs.push_back({1'b0, 1'b1, 1'b0, 4'd5, 3'b001, 4'd0, 1'b0});
    vecs.push_back({1'b0, 1'b1, 1'b0, 4'd6, 3'b001, 4'd0, 1'b0});
    vecs.push_back({1'b0, 1'b1, 1'b1, 4'd7, 3'b001, 4'd0, 1'b0});
    vecs.push_back({1'b0, 1'b1, 1'b0, 4'd8, 3'b001, 4'd0, 1'b0});
    vecs.push_back({1'b0, 1'b1, 1'b1, 4'd0, 3'b000, 4'd0, 1'b0});
    vecs.push_back({1'b1, 1'b0, 1'b1, 4'd1, 3'b000, 4'd1, 1'b0});
    vecs.push_back({1'b1, 1'b0, 1'b0, 4'd2, 3'b000, 4'd2, 1'b0});
    vecs.push_back({1'b1, 1'b0, 1'b1, 4'd3, 3'b000, 4'd3, 1'b0});
    vecs.push_back({1'b1, 1'b0, 1'b1, 4'd4, 3'b000, 4'd4, 1'b0});
    vecs.push_back({1'b1, 1'b0, 1'b0, 4'd5, 3'b000, 4'd5, 1'b0});
    vecs.push_back({1'b1, 1'b0, 1'b0, 4'd6, 3'b000, 4'd6, 1'b0});
    vecs.push_back({1'b1, 1'b0, 1'b1, 4'd7, 3'b000, 4'd7, 1'b0});
    vecs.push_back({1'b1, 1'b0, 1'b0, 4'd8, 3'b010, 4'd8, 1'b1});
    vecs.push_back({1'b1, 1'b0, 1'b0, 4'd8, 3'b010, 4'd8, 1'b1});
    vecs.push_back({1'b0, 1'b1, 1'b0, 4'd8, 3'b010, 4'd8, 1'b1});

    do_reset();
    check("reset leds", leds, 4'd0);
    check("reset rgb1", rgb_led1, 3'b001);
    check("reset rgb2", rgb_led2, 3'b001);
    check("reset gpio_out", ps_gpio_out, 4'd0);
    check("reset unlocked", unlocked, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      set_btn = vecs[i].sb;
      strobe_start(vecs[i].is_guess, vecs[i].b, p);
      check($sformatf("vec%0d leds", i), leds, vecs[i].leds);
      check($sformatf("vec%0d rgb1", i), rgb_led1, vecs[i].rgb);
      check($sformatf("vec%0d rgb2", i), rgb_led2, vecs[i].rgb);
      check($sformatf("vec%0d gpio_out", i), ps_gpio_out, vecs[i].gpio);
      check($sformatf("vec%0d unlocked", i), unlocked, vecs[i].unl);
      strobe_end(vecs[i].is_guess, vecs[i].b);
    end
    set_btn = 1'b0;

    // Broken run: 1,2,3,2 then flash lasts exactly FLASH_CYCLES cycles.
    do_reset();
    enter_secret(8'b10110010);
    guesses(16'b1010, 4, "t3", m1);
    check("t3 len", ps_gpio_out, 4'd2);
    check("t3 flash_on", rgb_led1, 3'b100);
    wait_cyc(m1 + FLASH_CYCLES - 1);
    check("t3 flash_last", rgb_led1, 3'b100);
    wait_cyc(m1 + FLASH_CYCLES);
    check("t3 flash_off", rgb_led1, 3'b000);

    // A second mismatch during flash restarts the timer.
    do_reset();
    enter_secret(8'b10110010);
    do_strobe(1'b1, 1'b0, "retrig_g1", m1);
    do_strobe(1'b1, 1'b0, "retrig_g2", m2);
    wait_cyc(m1 + FLASH_CYCLES);
    check("retrig extended", rgb_led1, 3'b100);
    wait_cyc(m2 + FLASH_CYCLES - 1);
    check("retrig last", rgb_led1, 3'b100);
    wait_cyc(m2 + FLASH_CYCLES);
    check("retrig off", rgb_led1, 3'b000);

    // Restart mid-sequence: 1,1 then the rest of the secret.
    do_reset();
    enter_secret(8'b10110010);
    guesses(16'b110110010, 9, "t4", p);
    check("t4 unlocked", unlocked, 1'b1);
    check("t4 len", ps_gpio_out, 4'd8);

    // Three mismatches then the correct sequence.
    do_reset();
    enter_secret(8'b10110010);
    guesses(16'b000, 3, "t5a", p);
    guesses(16'b10110010, 8, "t5b", p);
`ifdef SEQ_DET_LOCKOUT_EN
    check("t5 rgb", rgb_led1, 3'b101);
    check("t5 gpio_out", ps_gpio_out, 4'd0);
    check("t5 unlocked", unlocked, 1'b0);
`else
    check("t5 rgb", rgb_led1, 3'b010);
    check("t5 unlocked", unlocked, 1'b1);
`endif

    // Two mismatches (one below the lockout limit) still allow an unlock.
    do_reset();
    enter_secret(8'b10110010);
    guesses(16'b0010110010, 10, "t5c", p);
    check("t5c unlocked", unlocked, 1'b1);

    // Asynchronous reset in the middle of a run.
    do_reset();
    enter_secret(8'b10110010);
    guesses(16'b10110, 5, "t6", p);
    check("t6 len", ps_gpio_out, 4'd5);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t6 async leds", leds, 4'd0);
    check("t6 async gpio_out", ps_gpio_out, 4'd0);
    check("t6 async rgb1", rgb_led1, 3'b001);
    check("t6 async rgb2", rgb_led2, 3'b001);
    check("t6 async unlocked", unlocked, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Randomized secrets and guesses biased toward progress.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      rs = 8'($urandom);
      enter_secret(rs);
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 12)) @(negedge clk);
        if (m_match < SEQ_LEN && $urandom_range(0, 9) < 8) rb = m_secret[m_match];
        else rb = 1'($urandom_range(0, 1));
        do_strobe(1'b1, rb, $sformatf("rand%0d_%0d", r, i), p);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
